// File: rtl/sdr_arbiter.sv
// Round-robin arbiter sharing one avalon_sdr transfer engine between NREQ clients.
// Latches one request at a time, issues a start pulse, and returns completion to the owner.
module sdr_arbiter #(
   parameter int unsigned NREQ       = 4,
   parameter int unsigned MAX_NREAD  = 1,
   parameter int unsigned MAX_NWRITE = 1,
   parameter int unsigned TIMEOUT    = 4096
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic [NREQ-1:0]                req_valid,
   input  logic [NREQ-1:0]                req_write,
   input  logic [32*NREQ-1:0]             req_baseaddr,
   input  logic [30*NREQ-1:0]             req_nelems,
   input  logic [32*MAX_NWRITE*NREQ-1:0]  req_writedata,
   output logic [NREQ-1:0]                req_ack,
   output logic [NREQ-1:0]                req_done,
   output logic                           rsp_error,
   output logic [32*MAX_NREAD-1:0]        rsp_readdata,
   output logic                           halted,
   output logic [31:0]                    sdr_baseaddr,
   output logic [29:0]                    sdr_nelems,
   output logic [32*MAX_NWRITE-1:0]       sdr_writedata,
   output logic                           sdr_readstart,
   output logic                           sdr_writestart,
   input  logic [32*MAX_NREAD-1:0]        sdr_readdata,
   input  logic                           sdr_readend,
   input  logic                           sdr_writeend
);

   localparam int unsigned IDW     = $clog2(NREQ);
   localparam int unsigned WW      = 32 * MAX_NWRITE;
   localparam int unsigned RW      = 32 * MAX_NREAD;
   localparam logic [29:0] LIM_WR  = 30'(MAX_NWRITE);
   localparam logic [29:0] LIM_RD  = 30'(MAX_NREAD);
   localparam logic [31:0] WD_LAST = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, HALT} state_t;

   state_t           state, state_d;
   logic [IDW-1:0]   ptr, ptr_d, id, id_d;
   logic             wr, wr_d, err, err_d;
   logic [31:0]      cnt, cnt_d;
   logic [NREQ-1:0]  ack_d, done_d;
   logic             rsp_error_d, halted_d, rstart_d, wstart_d;
   logic [RW-1:0]    rdata_d;
   logic [31:0]      baddr_d;
   logic [29:0]      nel_d;
   logic [WW-1:0]    wdat_d;

   logic [31:0]      addr_a [NREQ];
   logic [29:0]      nel_a  [NREQ];
   logic [WW-1:0]    wd_a   [NREQ];

   for (genvar g = 0; g < NREQ; g++) begin : g_unpack
      assign addr_a[g] = req_baseaddr[32*g +: 32];
      assign nel_a[g]  = req_nelems[30*g +: 30];
      assign wd_a[g]   = req_writedata[WW*g +: WW];
   end

   // First requesting client at or after ptr, wrapping modulo NREQ.
   logic             found;
   logic [IDW-1:0]   sel, cand;

   always_comb begin
      found = 1'b0;
      sel   = '0;
      cand  = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         cand = IDW'((32'(ptr) + k) % NREQ);
         if (!found && req_valid[cand]) begin
            found = 1'b1;
            sel   = cand;
         end
      end
   end

   logic rej, end_hit;

   always_comb begin
      state_d     = state;
      ptr_d       = ptr;
      id_d        = id;
      wr_d        = wr;
      err_d       = err;
      cnt_d       = cnt;
      ack_d       = '0;
      done_d      = '0;
      rsp_error_d = 1'b0;
      rdata_d     = rsp_readdata;
      halted_d    = halted;
      baddr_d     = sdr_baseaddr;
      nel_d       = sdr_nelems;
      wdat_d      = sdr_writedata;
      rstart_d    = 1'b0;
      wstart_d    = 1'b0;
      rej         = 1'b0;
      end_hit     = wr ? sdr_writeend : sdr_readend;

      unique case (state)
         IDLE: begin
            if (found) begin
               rej = (nel_a[sel] == '0) ||
                     (req_write[sel] ? (nel_a[sel] > LIM_WR) : (nel_a[sel] > LIM_RD));
               id_d       = sel;
               wr_d       = req_write[sel];
               err_d      = rej;
               cnt_d      = '0;
               baddr_d    = addr_a[sel];
               nel_d      = nel_a[sel];
               wdat_d     = wd_a[sel];
               ack_d[sel] = 1'b1;
               wstart_d   = !rej && req_write[sel];
               rstart_d   = !rej && !req_write[sel];
               state_d    = ISSUE;
            end
         end
         ISSUE: begin
            if (err) begin
               done_d[id]  = 1'b1;
               rsp_error_d = 1'b1;
               baddr_d     = '0;
               nel_d       = '0;
               wdat_d      = '0;
               state_d     = DONE;
            end else begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (end_hit) begin
               done_d[id] = 1'b1;
               if (!wr) rdata_d = sdr_readdata;
               baddr_d    = '0;
               nel_d      = '0;
               wdat_d     = '0;
               state_d    = DONE;
            end else if (TIMEOUT != 0 && cnt == WD_LAST) begin
               done_d[id]  = 1'b1;
               rsp_error_d = 1'b1;
               halted_d    = 1'b1;
               baddr_d     = '0;
               nel_d       = '0;
               wdat_d      = '0;
               state_d     = HALT;
            end else begin
               cnt_d = cnt + 32'd1;
            end
         end
         DONE: begin
            ptr_d   = IDW'((32'(id) + 32'd1) % NREQ);
            state_d = IDLE;
         end
         HALT: state_d = HALT;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state          <= IDLE;
         ptr            <= '0;
         id             <= '0;
         wr             <= 1'b0;
         err            <= 1'b0;
         cnt            <= '0;
         req_ack        <= '0;
         req_done       <= '0;
         rsp_error      <= 1'b0;
         rsp_readdata   <= '0;
         halted         <= 1'b0;
         sdr_baseaddr   <= '0;
         sdr_nelems     <= '0;
         sdr_writedata  <= '0;
         sdr_readstart  <= 1'b0;
         sdr_writestart <= 1'b0;
      end else begin
         state          <= state_d;
         ptr            <= ptr_d;
         id             <= id_d;
         wr             <= wr_d;
         err            <= err_d;
         cnt            <= cnt_d;
         req_ack        <= ack_d;
         req_done       <= done_d;
         rsp_error      <= rsp_error_d;
         rsp_readdata   <= rdata_d;
         halted         <= halted_d;
         sdr_baseaddr   <= baddr_d;
         sdr_nelems     <= nel_d;
         sdr_writedata  <= wdat_d;
         sdr_readstart  <= rstart_d;
         sdr_writestart <= wstart_d;
      end
   end

endmodule

// File: tb/tb_sdr_arbiter.sv
// Directed and randomized checks of sdr_arbiter against a round-robin reference model.
module tb_sdr_arbiter;

   localparam int unsigned NREQ = 4;
   localparam int unsigned MAXR = 2;
   localparam int unsigned MAXW = 1;
   localparam int unsigned TMO  = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                     reset_n;
   logic [NREQ-1:0]          req_valid, req_write, req_ack, req_done;
   logic [32*NREQ-1:0]       req_baseaddr;
   logic [30*NREQ-1:0]       req_nelems;
   logic [32*MAXW*NREQ-1:0]  req_writedata;
   logic                     rsp_error, halted;
   logic [32*MAXR-1:0]       rsp_readdata, sdr_readdata;
   logic [31:0]              sdr_baseaddr;
   logic [29:0]              sdr_nelems;
   logic [32*MAXW-1:0]       sdr_writedata;
   logic                     sdr_readstart, sdr_writestart, sdr_readend, sdr_writeend;

   bit          c_valid [NREQ];
   bit          c_write [NREQ];
   logic [31:0] c_addr  [NREQ];
   logic [29:0] c_nel   [NREQ];
   logic [31:0] c_wd    [NREQ];

   for (genvar g = 0; g < NREQ; g++) begin : g_pack
      assign req_valid[g]              = c_valid[g];
      assign req_write[g]              = c_write[g];
      assign req_baseaddr[32*g +: 32]  = c_addr[g];
      assign req_nelems[30*g +: 30]    = c_nel[g];
      assign req_writedata[32*g +: 32] = c_wd[g];
   end

   sdr_arbiter #(.NREQ(NREQ), .MAX_NREAD(MAXR), .MAX_NWRITE(MAXW), .TIMEOUT(TMO)) dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_write(req_write), .req_baseaddr(req_baseaddr),
      .req_nelems(req_nelems), .req_writedata(req_writedata),
      .req_ack(req_ack), .req_done(req_done), .rsp_error(rsp_error),
      .rsp_readdata(rsp_readdata), .halted(halted),
      .sdr_baseaddr(sdr_baseaddr), .sdr_nelems(sdr_nelems), .sdr_writedata(sdr_writedata),
      .sdr_readstart(sdr_readstart), .sdr_writestart(sdr_writestart),
      .sdr_readdata(sdr_readdata), .sdr_readend(sdr_readend), .sdr_writeend(sdr_writeend)
   );

   int          total = 0;
   int          bad = 0;
   int          m_ptr = 0;
   logic [63:0] m_rd = '0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic int rr_pick(input logic [NREQ-1:0] mask, input int p);
      for (int k = 0; k < NREQ; k++)
         if (mask[(p + k) % NREQ]) return (p + k) % NREQ;
      return 0;
   endfunction

   function automatic logic [NREQ-1:0] cur_mask();
      logic [NREQ-1:0] m;
      for (int i = 0; i < NREQ; i++) m[i] = c_valid[i];
      return m;
   endfunction

   task automatic chk_quiet(input string tag);
      chk({tag, "_ack"}, req_ack, 0);
      chk({tag, "_done"}, req_done, 0);
      chk({tag, "_err"}, rsp_error, 0);
      chk({tag, "_start"}, {sdr_readstart, sdr_writestart}, 0);
      chk({tag, "_fields"}, {sdr_baseaddr, sdr_nelems, sdr_writedata}, 0);
   endtask

   task automatic set_req(input int i, input bit w, input logic [31:0] a,
                          input logic [29:0] n, input logic [31:0] d);
      c_valid[i] = 1'b1;
      c_write[i] = w;
      c_addr[i]  = a;
      c_nel[i]   = n;
      c_wd[i]    = d;
   endtask

   task automatic clear_all();
      for (int i = 0; i < NREQ; i++) c_valid[i] = 1'b0;
   endtask

   // Called in an IDLE cycle with requests already driven; returns in the following IDLE cycle.
   task automatic xfer(input int id, input int lat, input bit drop, input bit mutate);
      logic [31:0] e_addr, e_wd;
      logic [29:0] e_nel;
      logic [63:0] word;
      bit          e_wr, rej;
      e_addr = c_addr[id];
      e_wd   = c_wd[id];
      e_nel  = c_nel[id];
      e_wr   = c_write[id];
      rej    = (e_nel == 0) || (e_wr ? (e_nel > MAXW) : (e_nel > MAXR));
      word   = '0;
      @(negedge clk);
      chk_quiet("idle");
      cyc();
      if (drop) c_valid[id] = 1'b0;
      if (mutate) begin
         c_addr[id] = ~e_addr;
         c_wd[id]   = e_wd ^ 32'h5a5a_5a5a;
      end
      @(negedge clk);
      chk("ack", req_ack, 64'(1) << id);
      chk("wstart", sdr_writestart, !rej && e_wr);
      chk("rstart", sdr_readstart, !rej && !e_wr);
      chk("issue_addr", sdr_baseaddr, e_addr);
      if (rej) begin
         cyc();
         @(negedge clk);
         chk("rej_done", req_done, 64'(1) << id);
         chk("rej_err", rsp_error, 1);
         chk("rej_quiet", {req_ack, sdr_readstart, sdr_writestart, sdr_baseaddr}, 0);
      end else begin
         for (int k = 1; k <= lat; k++) begin
            cyc();
            sdr_readend  = 1'b0;
            sdr_writeend = 1'b0;
            sdr_readdata = {$urandom, $urandom};
            if (k == lat) begin
               word = sdr_readdata;
               if (e_wr) sdr_writeend = 1'b1;
               else sdr_readend = 1'b1;
            end else if ($urandom_range(0, 3) == 0) begin
               if (e_wr) sdr_readend = 1'b1;
               else sdr_writeend = 1'b1;
            end
            @(negedge clk);
            chk("wait_fields", {sdr_baseaddr, sdr_nelems, sdr_writedata}, {e_addr, e_nel, e_wd});
            chk("wait_quiet", {req_done, req_ack, sdr_readstart, sdr_writestart}, 0);
         end
         cyc();
         sdr_readend  = 1'b0;
         sdr_writeend = 1'b0;
         sdr_readdata = {$urandom, $urandom};
         @(negedge clk);
         if (!e_wr) m_rd = word;
         chk("done", req_done, 64'(1) << id);
         chk("done_err", rsp_error, 0);
         chk("readdata", rsp_readdata, m_rd);
         chk("done_fields", {sdr_baseaddr, sdr_nelems, sdr_writedata, halted}, 0);
      end
      m_ptr = (id + 1) % NREQ;
      cyc();
   endtask

   initial begin
      int exp_id;
      logic [NREQ-1:0] mask;
      reset_n      = 1'b0;
      sdr_readdata = '0;
      sdr_readend  = 1'b0;
      sdr_writeend = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         c_valid[i] = 1'b0; c_write[i] = 1'b0; c_addr[i] = '0; c_nel[i] = '0; c_wd[i] = '0;
      end
      repeat (3) cyc();
      @(negedge clk);
      chk_quiet("rst");
      chk("rst_state", {rsp_readdata, halted}, 0);

      // Single read with a 5-cycle engine latency.
      cyc();
      reset_n = 1'b1;
      set_req(0, 1'b0, 32'h100, 30'd1, 32'h0);
      xfer(0, 5, 1, 0);

      // Contention from a freshly reset pointer.
      reset_n = 1'b0;
      cyc();
      reset_n = 1'b1;
      m_ptr = 0;
      m_rd  = '0;
      set_req(0, 1'b0, 32'h1000, 30'd2, 32'h0);
      set_req(1, 1'b1, 32'h2000, 30'd1, 32'hcafe_0001);
      set_req(2, 1'b0, 32'h3000, 30'd1, 32'h0);
      xfer(0, 3, 0, 0);
      xfer(1, 2, 0, 0);
      xfer(2, 4, 0, 0);
      xfer(0, 1, 0, 0);
      clear_all();

      // Length limits: rejects and exact-limit acceptances.
      set_req(3, 1'b1, 32'h40, 30'd0, 32'h1111_1111);
      xfer(3, 1, 1, 0);
      set_req(3, 1'b1, 32'h44, 30'(MAXW + 1), 32'h2222_2222);
      xfer(3, 1, 1, 0);
      set_req(2, 1'b0, 32'h48, 30'(MAXR + 1), 32'h0);
      xfer(2, 1, 1, 0);
      set_req(2, 1'b0, 32'h4c, 30'(MAXR), 32'h0);
      xfer(2, 2, 1, 0);
      set_req(3, 1'b1, 32'h50, 30'(MAXW), 32'h3333_3333);
      xfer(3, 2, 1, 0);

      // Request fields change right after ack.
      set_req(1, 1'b1, 32'hbeef_0000, 30'd1, 32'h1234_5678);
      xfer(1, 6, 1, 1);

      // Randomized requests against the round-robin model.
      for (int r = 0; r < 24; r++) begin
         mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
         for (int i = 0; i < NREQ; i++) begin
            set_req(i, 1'($urandom), $urandom, 30'($urandom_range(0, 3)), $urandom);
            c_valid[i] = mask[i];
         end
         exp_id = rr_pick(mask, m_ptr);
         xfer(exp_id, $urandom_range(1, 10), 1, 1'($urandom));
         clear_all();
      end

      // Reset during WAIT: pointer must restart at client 0.
      set_req(2, 1'b1, 32'h600, 30'd1, 32'h6666_6666);
      xfer(2, 2, 1, 0);
      set_req(3, 1'b0, 32'h700, 30'd1, 32'h0);
      exp_id = rr_pick(cur_mask(), m_ptr);
      @(negedge clk);
      cyc();
      c_valid[3] = 1'b0;
      @(negedge clk);
      chk("mid_ack", req_ack, 64'(1) << exp_id);
      cyc();
      cyc();
      reset_n = 1'b0;
      cyc();
      reset_n = 1'b1;
      sdr_readend = 1'b1;
      m_ptr = 0;
      m_rd  = '0;
      @(negedge clk);
      chk_quiet("mid_rst");
      chk("mid_rst_state", {rsp_readdata, halted}, 0);
      cyc();
      sdr_readend = 1'b0;
      @(negedge clk);
      chk("mid_rst_nodone", req_done, 0);
      cyc();
      set_req(1, 1'b0, 32'h800, 30'd1, 32'h0);
      set_req(3, 1'b0, 32'h900, 30'd1, 32'h0);
      xfer(1, 3, 1, 0);
      clear_all();

      // Watchdog: no end pulse ever arrives.
      set_req(0, 1'b0, 32'ha00, 30'd1, 32'h0);
      set_req(2, 1'b1, 32'hb00, 30'd1, 32'hdead_beef);
      exp_id = rr_pick(cur_mask(), m_ptr);
      clear_all();
      c_valid[exp_id] = 1'b1;
      @(negedge clk);
      cyc();
      c_valid[exp_id] = 1'b0;
      @(negedge clk);
      chk("wd_ack", req_ack, 64'(1) << exp_id);
      for (int k = 1; k <= TMO; k++) begin
         cyc();
         @(negedge clk);
         chk("wd_wait", {req_done, halted}, 0);
      end
      cyc();
      @(negedge clk);
      chk("wd_done", req_done, 64'(1) << exp_id);
      chk("wd_err", rsp_error, 1);
      chk("wd_halted", halted, 1);
      for (int i = 0; i < NREQ; i++) c_valid[i] = 1'b1;
      for (int k = 0; k < 6; k++) begin
         cyc();
         @(negedge clk);
         chk_quiet("halt");
         chk("halt_sticky", halted, 1);
      end
      clear_all();
      reset_n = 1'b0;
      cyc();
      reset_n = 1'b1;
      @(negedge clk);
      chk("halt_cleared", halted, 0);
      chk_quiet("halt_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
